// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for an in-order N-stage RV32I pipeline:
// in-flight destination scoreboard, stage enable/clear strobes, EX forwarding selects, perf counters.
module pipe_hazard_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int REG_AW     = 5,
  parameter int LOAD_LAT   = 1,
  parameter int BR_STAGE   = 3,
  parameter int CNT_W      = 16,
  localparam int SW        = $clog2(NUM_STAGES - 2)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_id_vld,
  input  logic [REG_AW-1:0]     i_id_rs1_addr,
  input  logic [REG_AW-1:0]     i_id_rs2_addr,
  input  logic                  i_id_rs1_use,
  input  logic                  i_id_rs2_use,
  input  logic [REG_AW-1:0]     i_id_rd_addr,
  input  logic                  i_id_rd_wren,
  input  logic                  i_id_is_load,
  input  logic                  i_br_taken,
  input  logic                  i_mem_wait,
  output logic [NUM_STAGES-1:0] o_stage_en,
  output logic [NUM_STAGES-1:0] o_stage_clr,
  output logic [SW-1:0]         o_fwd_sel_a,
  output logic [SW-1:0]         o_fwd_sel_b,
  output logic [CNT_W-1:0]      o_stall_cnt,
  output logic [CNT_W-1:0]      o_flush_cnt
);

  // The WB entry retires into a write-first register file, so only EX..N-2 are ever consulted.
  localparam int SB_TOP = NUM_STAGES - 2;
  localparam logic [NUM_STAGES-1:0] BR_CLR_MASK =
    NUM_STAGES'((64'd1 << (BR_STAGE + 1)) - 64'd2);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [SB_TOP:2]       r_vld;
  logic [SB_TOP:2]       r_wren;
  logic [SB_TOP:2]       r_load;
  logic [REG_AW-1:0]     r_rd [SB_TOP:2];
  logic [SW-1:0]         r_fwd_a;
  logic [SW-1:0]         r_fwd_b;
  logic [CNT_W-1:0]      r_stall_cnt;
  logic [CNT_W-1:0]      r_flush_cnt;

  logic [SB_TOP:2]       w_wr;
  logic                  w_luse_raw;
  logic                  w_luse;
  logic                  w_flush;
  logic                  w_id_adv;
  logic [SW-1:0]         w_sel_a;
  logic [SW-1:0]         w_sel_b;
  logic [NUM_STAGES-1:0] w_en;
  logic [NUM_STAGES-1:0] w_clr;

  // Scoreboard lookup: writer flags, load-use detection and youngest-writer forwarding selects.
  always_comb begin
    w_wr       = '0;
    w_luse_raw = 1'b0;
    w_sel_a    = '0;
    w_sel_b    = '0;
    for (int k = 2; k <= SB_TOP; k++) begin
      w_wr[k] = r_vld[k] & r_wren[k] & (r_rd[k] != '0);
      w_luse_raw = w_luse_raw | ((k < 2 + LOAD_LAT) & w_wr[k] & r_load[k] & i_id_vld &
                   ((i_id_rs1_use & (i_id_rs1_addr == r_rd[k])) |
                    (i_id_rs2_use & (i_id_rs2_addr == r_rd[k]))));
    end
    // Walk oldest to youngest so the youngest matching writer wins.
    for (int k = SB_TOP; k >= 2; k--) begin
      w_sel_a = (w_wr[k] & i_id_rs1_use & (i_id_rs1_addr == r_rd[k])) ? SW'(k - 1) : w_sel_a;
      w_sel_b = (w_wr[k] & i_id_rs2_use & (i_id_rs2_addr == r_rd[k])) ? SW'(k - 1) : w_sel_b;
    end
  end

  assign w_flush  = i_br_taken & ~i_mem_wait;
  assign w_luse   = w_luse_raw & ~i_mem_wait & ~i_br_taken;
  assign w_id_adv = i_id_vld & ~i_mem_wait & ~i_br_taken & ~w_luse_raw;

  // Pipeline register strobes: mem_wait freezes, branch flushes the front end, load-use bubbles EX.
  always_comb begin
    w_en  = {NUM_STAGES{1'b1}};
    w_clr = {NUM_STAGES{1'b0}};
    if (i_mem_wait) begin
      w_en  = {NUM_STAGES{1'b0}};
      w_clr = {NUM_STAGES{1'b0}};
    end else if (w_flush) begin
      w_clr = BR_CLR_MASK;
    end else if (w_luse) begin
      w_en[1:0] = 2'b00;
      w_clr[2]  = 1'b1;
    end else begin
      w_en  = {NUM_STAGES{1'b1}};
      w_clr = {NUM_STAGES{1'b0}};
    end
  end

  // Scoreboard shift and registered EX forwarding selects; everything holds during mem_wait.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_vld   <= '0;
      r_wren  <= '0;
      r_load  <= '0;
      r_fwd_a <= '0;
      r_fwd_b <= '0;
      for (int k = 2; k <= SB_TOP; k++) begin
        r_rd[k] <= '0;
      end
    end else if (!i_mem_wait) begin
      for (int k = SB_TOP; k > 2; k--) begin
        r_vld[k]  <= r_vld[k-1] & ~(w_flush & (k <= BR_STAGE));
        r_wren[k] <= r_wren[k-1];
        r_load[k] <= r_load[k-1];
        r_rd[k]   <= r_rd[k-1];
      end
      r_vld[2]  <= w_id_adv;
      r_wren[2] <= i_id_rd_wren;
      r_load[2] <= i_id_is_load;
      r_rd[2]   <= i_id_rd_addr;
      r_fwd_a   <= w_id_adv ? w_sel_a : '0;
      r_fwd_b   <= w_id_adv ? w_sel_b : '0;
    end
  end

  // Saturating load-use stall and branch flush counters.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_luse && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if (w_flush && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end
    end
  end

  assign o_stage_en  = w_en;
  assign o_stage_clr = w_clr;
  assign o_fwd_sel_a = r_fwd_a;
  assign o_fwd_sel_b = r_fwd_b;
  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule
